// File: rtl/filter_fir_pkg.sv
// Shared constants and helpers for the 5-tap FIR low-pass filter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package filter_fir_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OUT_W  = 10;
    localparam int unsigned NTAPS  = 5;

    // Default low-pass kernel 1-2-2-2-1 (gain 8, halved by the default SHIFT).
    localparam int unsigned DEF_C0 = 1;
    localparam int unsigned DEF_C1 = 2;
    localparam int unsigned DEF_C2 = 2;
    localparam int unsigned DEF_C3 = 2;
    localparam int unsigned DEF_C4 = 1;

    localparam logic [OUT_W-1:0] OUT_MAX = 10'd1023;

    // Full-precision accumulator width: sample x coefficient product plus
    // three guard bits, enough for the sum of five maximum-size products.
    function automatic int unsigned acc_width(input int unsigned coef_w);
        return DATA_W + coef_w + 3;
    endfunction

endpackage

// File: rtl/filter_fir_tap_mac.sv
// One FIR tap: sample x coefficient product added onto an incoming partial sum.
// Latency: combinational, zero cycles.
// Backpressure: none; evaluated every clock.
// Ports: sample (8b data), coef (COEF_W), acc_in / acc_out (ACC_W partial sums).
module fir_tap_mac
    import filter_fir_pkg::*;
#(
    parameter int unsigned COEF_W = 4,
    parameter int unsigned ACC_W  = 15
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [COEF_W-1:0] coef,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  acc_out
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;

    logic [PROD_W-1:0] prod;

    // Zero-extend both operands to the product width so the multiply is
    // evaluated at full precision.
    assign prod    = {{COEF_W{1'b0}}, sample} * {{DATA_W{1'b0}}, coef};
    assign acc_out = acc_in + ACC_W'(prod);

endmodule

// File: rtl/filter_fir.sv
// Unsigned 5-tap direct-form FIR low-pass, one 8-bit sample in, one 10-bit sample out per clock.
// Latency: one register stage (dataout after edge k uses x at k..k-4).
// Backpressure: none; every clock is a sample, no handshake.
// Ports: clk (rising edge), rst (sync active-low), x (8b sample), dataout (10b registered).
// Build option: FILTERFIR_SAT_EN defined -> clamp to 1023; undefined -> wrap to 10 bits.
module filter_fir
    import filter_fir_pkg::*;
#(
    parameter int unsigned COEF_W = 4,
    parameter int unsigned C0     = DEF_C0,
    parameter int unsigned C1     = DEF_C1,
    parameter int unsigned C2     = DEF_C2,
    parameter int unsigned C3     = DEF_C3,
    parameter int unsigned C4     = DEF_C4,
    parameter int unsigned SHIFT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x,
    output logic [OUT_W-1:0]  dataout
);

    localparam int unsigned ACC_W = acc_width(COEF_W);

    logic [DATA_W-1:0] d1, d2, d3, d4;
    logic [ACC_W-1:0]  p0, p01, p4, p43, p432;
    logic [ACC_W-1:0]  acc, scaled;
    logic [OUT_W-1:0]  conv;

    // Taps are split into two short chains joined by one final adder, so the
    // late-arriving x only sees two adds plus the join instead of five.
    fir_tap_mac #(.COEF_W(COEF_W), .ACC_W(ACC_W)) u_tap0 (
        .sample(x),  .coef(COEF_W'(C0)), .acc_in('0),  .acc_out(p0)
    );
    fir_tap_mac #(.COEF_W(COEF_W), .ACC_W(ACC_W)) u_tap1 (
        .sample(d1), .coef(COEF_W'(C1)), .acc_in(p0),  .acc_out(p01)
    );
    fir_tap_mac #(.COEF_W(COEF_W), .ACC_W(ACC_W)) u_tap4 (
        .sample(d4), .coef(COEF_W'(C4)), .acc_in('0),  .acc_out(p4)
    );
    fir_tap_mac #(.COEF_W(COEF_W), .ACC_W(ACC_W)) u_tap3 (
        .sample(d3), .coef(COEF_W'(C3)), .acc_in(p4),  .acc_out(p43)
    );
    fir_tap_mac #(.COEF_W(COEF_W), .ACC_W(ACC_W)) u_tap2 (
        .sample(d2), .coef(COEF_W'(C2)), .acc_in(p43), .acc_out(p432)
    );

    // ACC_W carries enough guard bits that this sum cannot overflow.
    assign acc    = p01 + p432;
    assign scaled = acc >> SHIFT;

    always_comb begin
        conv = scaled[OUT_W-1:0];
`ifdef FILTERFIR_SAT_EN
        if (scaled > ACC_W'(OUT_MAX)) begin
            conv = OUT_MAX;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d1      <= '0;
            d2      <= '0;
            d3      <= '0;
            d4      <= '0;
            dataout <= '0;
        end else begin
            d1      <= x;
            d2      <= d1;
            d3      <= d2;
            d4      <= d3;
            dataout <= conv;
        end
    end

endmodule

// File: tb/tb_filter_fir.sv
module tb_filter_fir;

    logic       clk;
    logic       rst;
    logic [7:0] x;
    logic [9:0] dataout;
    logic [9:0] dataout_sh0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [7:0] x;
        logic [9:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

`ifdef FILTERFIR_SAT_EN
    localparam logic [9:0] EXP_OVF = 10'd1023;
`else
    localparam logic [9:0] EXP_OVF = 10'd1016;
`endif

    filter_fir u_dut (
        .clk(clk), .rst(rst), .x(x), .dataout(dataout)
    );

    filter_fir #(.SHIFT(0)) u_sh0 (
        .clk(clk), .rst(rst), .x(x), .dataout(dataout_sh0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, let one rising edge pass, then sit 1 ns after it.
    task automatic tick(input logic rv, input logic [7:0] xv);
        rst = rv;
        x   = xv;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic rv, input logic [7:0] xv, input logic [9:0] e, input string n);
        vec_t v;
        v.rst = rv; v.x = xv; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    // Reset edge, then a step to a constant xv: five ramp outputs plus one steady.
    task automatic seg(input logic [7:0] xv, input logic [9:0] a, input logic [9:0] b,
                       input logic [9:0] c, input logic [9:0] d, input logic [9:0] e,
                       input string n);
        push(1'b0, xv, 10'd0, {n, "_rst"});
        push(1'b1, xv, a, {n, "_e1"});
        push(1'b1, xv, b, {n, "_e2"});
        push(1'b1, xv, c, {n, "_e3"});
        push(1'b1, xv, d, {n, "_e4"});
        push(1'b1, xv, e, {n, "_e5"});
        push(1'b1, xv, e, {n, "_hold"});
    endtask

    initial begin
        rst = 1'b0;
        x   = 8'd0;

        // Reset held for 10 edges with x=200, then release.
        for (int i = 0; i < 10; i++) push(1'b0, 8'd200, 10'd0, "reset_hold");
        push(1'b1, 8'd200, 10'd100, "release_first");
        seg(8'd5,   10'd2,   10'd7,   10'd12,  10'd17,  10'd20,   "step5");
        seg(8'd10,  10'd5,   10'd15,  10'd25,  10'd35,  10'd40,   "x10");
        seg(8'd12,  10'd6,   10'd18,  10'd30,  10'd42,  10'd48,   "x12");
        seg(8'd15,  10'd7,   10'd22,  10'd37,  10'd52,  10'd60,   "x15");
        seg(8'd16,  10'd8,   10'd24,  10'd40,  10'd56,  10'd64,   "x16");
        seg(8'd255, 10'd127, 10'd382, 10'd637, 10'd892, 10'd1020, "x255");

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].rst, vecs[i].x);
            chk(vecs[i].name, dataout, vecs[i].exp);
            if (i < 10) begin
                chk("reset_d1", {2'b00, u_dut.d1}, 10'd0);
                chk("reset_d4", {2'b00, u_dut.d4}, 10'd0);
            end
        end

        // SHIFT=0 instance with full-scale input: 255 x 8 = 2040 overflows 10 bits.
        tick(1'b0, 8'd255);
        chk("sh0_rst", dataout_sh0, 10'd0);
        tick(1'b1, 8'd255);
        chk("sh0_e1", dataout_sh0, 10'd255);
        for (int i = 0; i < 4; i++) tick(1'b1, 8'd255);
        chk("sh0_ovf", dataout_sh0, EXP_OVF);
        chk("full_scale_nosat", dataout, 10'd1020);
        tick(1'b1, 8'd255);
        chk("sh0_ovf_hold", dataout_sh0, EXP_OVF);

        // Mid-stream one-edge reset pulse from steady x=16.
        for (int i = 0; i < 6; i++) tick(1'b1, 8'd16);
        chk("mid_steady", dataout, 10'd64);
        tick(1'b0, 8'd16);
        chk("mid_rst", dataout, 10'd0);
        tick(1'b1, 8'd16); chk("mid_e1", dataout, 10'd8);
        tick(1'b1, 8'd16); chk("mid_e2", dataout, 10'd24);
        tick(1'b1, 8'd16); chk("mid_e3", dataout, 10'd40);
        tick(1'b1, 8'd16); chk("mid_e4", dataout, 10'd56);
        tick(1'b1, 8'd16); chk("mid_e5", dataout, 10'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
